// File: rtl/adc_seq_if.sv
// adc_seq_if -- handshake/status bundle between the ADC sequencer and its environment.
//   master : host/array side (drives run, conv_tick, cfg_upd, err_clr, fd_*; observes the rest)
//   slave  : sequencer side (adc_seq_ctrl)
//   run, conv_tick, cfg_upd, err_clr : host controls and strobes
//   fd_init/type/conf/conv           : AND-reduced stage done flags from the ADC array
//   fs_init/type/conf/conv           : stage start levels to the ADC array
//   ready, err, err_stage, overrun, conv_cnt, state : status
interface adc_seq_if #(
    parameter int unsigned CNT_W = 16
);
    logic             run;
    logic             conv_tick;
    logic             cfg_upd;
    logic             err_clr;
    logic             fd_init;
    logic             fd_type;
    logic             fd_conf;
    logic             fd_conv;
    logic             fs_init;
    logic             fs_type;
    logic             fs_conf;
    logic             fs_conv;
    logic             ready;
    logic             err;
    logic [1:0]       err_stage;
    logic             overrun;
    logic [CNT_W-1:0] conv_cnt;
    logic [2:0]       state;

    modport master (
        output run, conv_tick, cfg_upd, err_clr,
        output fd_init, fd_type, fd_conf, fd_conv,
        input  fs_init, fs_type, fs_conf, fs_conv,
        input  ready, err, err_stage, overrun, conv_cnt, state
    );

    modport slave (
        input  run, conv_tick, cfg_upd, err_clr,
        input  fd_init, fd_type, fd_conf, fd_conv,
        output fs_init, fs_type, fs_conf, fs_conv,
        output ready, err, err_stage, overrun, conv_cnt, state
    );
endinterface

// File: rtl/adc_seq_ctrl.sv
// adc_seq_ctrl -- bring-up and conversion sequencer for a four-chip ADC array.
// Walks INIT -> TYPE -> CONF -> WAIT, then runs one CONV per conv_tick, with a
// per-stage timeout into ERR. Pending tick/config requests are queued one deep.
//   clk : system clock (rising edge)
//   rst : asynchronous, active-high reset
//   bus : adc_seq_if.slave (controls, done flags in; start levels and status out)
module adc_seq_ctrl #(
    parameter logic [15:0] TIMEOUT = 16'd50000,
    parameter int unsigned CNT_W   = 16
) (
    input  logic      clk,
    input  logic      rst,
    adc_seq_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_INIT = 3'd1,
        S_TYPE = 3'd2,
        S_CONF = 3'd3,
        S_WAIT = 3'd4,
        S_CONV = 3'd5,
        S_ERR  = 3'd6
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           state_q, state_d;
    logic             armed_q;      // current stage has seen its done flag low
    logic [15:0]      tmo_q;
    logic             cfg_pend_q, cfg_pend_d;
    logic             tick_pend_q, tick_pend_d;
    logic             overrun_q;
    logic             ovr_set;
    logic [CNT_W-1:0] cnt_q;
    logic [1:0]       err_stage_q;
    logic [1:0]       stage_code;
    logic             fs_init_q, fs_type_q, fs_conf_q, fs_conv_q;
    logic             ready_q, err_q;
    logic             fd_cur;
    logic             done;
    logic             in_stage;
    logic             tmo_hit;
    logic             entry;

    // Next-state and pending-flag logic
    always_comb begin
        state_d     = state_q;
        cfg_pend_d  = cfg_pend_q;
        tick_pend_d = tick_pend_q;
        ovr_set     = 1'b0;
        fd_cur      = 1'b0;
        stage_code  = 2'd0;
        in_stage    = 1'b0;

        case (state_q)
            S_INIT: begin fd_cur = bus.fd_init; stage_code = 2'd0; in_stage = 1'b1; end
            S_TYPE: begin fd_cur = bus.fd_type; stage_code = 2'd1; in_stage = 1'b1; end
            S_CONF: begin fd_cur = bus.fd_conf; stage_code = 2'd2; in_stage = 1'b1; end
            S_CONV: begin fd_cur = bus.fd_conv; stage_code = 2'd3; in_stage = 1'b1; end
            default: ;
        endcase

        // A done flag only counts once it has been observed low in this stage
        done    = armed_q & fd_cur;
        tmo_hit = (tmo_q == (TIMEOUT - 16'd1));

        case (state_q)
            S_IDLE: if (bus.run) state_d = S_INIT;
            S_INIT: begin
                if (done)         state_d = bus.run ? S_TYPE : S_IDLE;
                else if (tmo_hit) state_d = S_ERR;
            end
            S_TYPE: begin
                if (done)         state_d = bus.run ? S_CONF : S_IDLE;
                else if (tmo_hit) state_d = S_ERR;
            end
            S_CONF: begin
                if (done)         state_d = bus.run ? S_WAIT : S_IDLE;
                else if (tmo_hit) state_d = S_ERR;
            end
            S_WAIT: begin
                if (!bus.run)                                state_d = S_IDLE;
                else if (cfg_pend_q || bus.cfg_upd)          state_d = S_CONF;
                else if (bus.conv_tick || tick_pend_q)       state_d = S_CONV;
            end
            S_CONV: begin
                if (done)         state_d = bus.run ? S_WAIT : S_IDLE;
                else if (tmo_hit) state_d = S_ERR;
            end
            S_ERR:  if (bus.err_clr) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        entry = (state_d != state_q);

        // Config request: queued outside WAIT/CONF, consumed on CONF entry
        if (state_q == S_IDLE)
            cfg_pend_d = 1'b0;
        else if (state_d == S_CONF && entry)
            cfg_pend_d = 1'b0;
        else if (bus.cfg_upd && state_q != S_WAIT && state_q != S_CONF)
            cfg_pend_d = 1'b1;

        // Tick request: one deep; a tick arriving with one already queued is lost
        if (state_q == S_IDLE) begin
            tick_pend_d = 1'b0;
        end else if (state_d == S_CONV && entry) begin
            tick_pend_d = 1'b0;
            ovr_set     = bus.conv_tick & tick_pend_q;
        end else if (bus.conv_tick &&
                     (state_q == S_CONV || state_q == S_CONF ||
                      (state_q == S_WAIT && state_d == S_CONF))) begin
            if (tick_pend_q) ovr_set = 1'b1;
            else             tick_pend_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            armed_q     <= 1'b0;
            tmo_q       <= '0;
            cfg_pend_q  <= 1'b0;
            tick_pend_q <= 1'b0;
            overrun_q   <= 1'b0;
            cnt_q       <= '0;
            err_stage_q <= 2'd0;
            fs_init_q   <= 1'b0;
            fs_type_q   <= 1'b0;
            fs_conf_q   <= 1'b0;
            fs_conv_q   <= 1'b0;
            ready_q     <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cfg_pend_q  <= cfg_pend_d;
            tick_pend_q <= tick_pend_d;

            if (entry)
                armed_q <= 1'b0;
            else if (!fd_cur)
                armed_q <= 1'b1;

            if (entry)
                tmo_q <= '0;
            else if (in_stage)
                tmo_q <= tmo_q + 16'd1;

            if (bus.err_clr)
                overrun_q <= 1'b0;
            else if (ovr_set)
                overrun_q <= 1'b1;

            if (state_q == S_CONV && done)
                cnt_q <= cnt_q + CNT_ONE;

            if (state_d == S_ERR && entry)
                err_stage_q <= stage_code;

            // Outputs registered from the next state so they align with state_q
            fs_init_q <= (state_d == S_INIT);
            fs_type_q <= (state_d == S_TYPE);
            fs_conf_q <= (state_d == S_CONF);
            fs_conv_q <= (state_d == S_CONV);
            ready_q   <= (state_d == S_WAIT);
            err_q     <= (state_d == S_ERR);
        end
    end

    assign bus.fs_init   = fs_init_q;
    assign bus.fs_type   = fs_type_q;
    assign bus.fs_conf   = fs_conf_q;
    assign bus.fs_conv   = fs_conv_q;
    assign bus.ready     = ready_q;
    assign bus.err       = err_q;
    assign bus.err_stage = err_stage_q;
    assign bus.overrun   = overrun_q;
    assign bus.conv_cnt  = cnt_q;
    assign bus.state     = state_q;

endmodule

// File: tb/tb_adc_seq_ctrl.sv
// tb_adc_seq_ctrl -- directed self-checking bench for adc_seq_ctrl
// (TIMEOUT=100, CNT_W=4).
module tb_adc_seq_ctrl;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    adc_seq_if #(.CNT_W(4)) bus ();

    adc_seq_ctrl #(
        .TIMEOUT (16'd100),
        .CNT_W   (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int unsigned n_chk = 0;
    int unsigned n_err = 0;

    logic [3:0] fs_vec;
    assign fs_vec = {bus.fs_init, bus.fs_type, bus.fs_conf, bus.fs_conv};

    task automatic step(input int unsigned n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic set_fd(input int unsigned idx, input logic v);
        case (idx)
            0: bus.fd_init = v;
            1: bus.fd_type = v;
            2: bus.fd_conf = v;
            default: bus.fd_conv = v;
        endcase
    endtask

    // done flag sampled high on the n-th edge after the current point
    task automatic fd_after(input int unsigned idx, input int unsigned n);
        step(n - 1);
        set_fd(idx, 1'b1);
        step(1);
        set_fd(idx, 1'b0);
    endtask

    task automatic pulse_tick();
        bus.conv_tick = 1'b1;
        step(1);
        bus.conv_tick = 1'b0;
    endtask

    task automatic pulse_cfg();
        bus.cfg_upd = 1'b1;
        step(1);
        bus.cfg_upd = 1'b0;
    endtask

    task automatic pulse_clr();
        bus.err_clr = 1'b1;
        step(1);
        bus.err_clr = 1'b0;
    endtask

    initial begin
        rst           = 1'b1;
        bus.run       = 1'b0;
        bus.conv_tick = 1'b0;
        bus.cfg_upd   = 1'b0;
        bus.err_clr   = 1'b0;
        bus.fd_init   = 1'b0;
        bus.fd_type   = 1'b0;
        bus.fd_conf   = 1'b0;
        bus.fd_conv   = 1'b0;
        step(3);

        // Reset values
        chk("rst_state",     32'(bus.state),     32'd0);
        chk("rst_fs",        32'(fs_vec),        32'd0);
        chk("rst_ready",     32'(bus.ready),     32'd0);
        chk("rst_err",       32'(bus.err),       32'd0);
        chk("rst_err_stage", 32'(bus.err_stage), 32'd0);
        chk("rst_overrun",   32'(bus.overrun),   32'd0);
        chk("rst_cnt",       32'(bus.conv_cnt),  32'd0);

        rst = 1'b0;
        step(2);
        chk("idle_hold", 32'(bus.state), 32'd0);

        // Bring-up
        bus.run = 1'b1;
        step(1);
        chk("init_state", 32'(bus.state), 32'd1);
        chk("init_fs",    32'(fs_vec),    32'b1000);
        fd_after(0, 3);
        chk("type_state", 32'(bus.state), 32'd2);
        chk("type_fs",    32'(fs_vec),    32'b0100);
        fd_after(1, 3);
        chk("conf_state", 32'(bus.state), 32'd3);
        chk("conf_fs",    32'(fs_vec),    32'b0010);
        fd_after(2, 3);
        chk("wait_state", 32'(bus.state), 32'd4);
        chk("wait_ready", 32'(bus.ready), 32'd1);
        chk("wait_fs",    32'(fs_vec),    32'b0000);

        // Ten conversions, 100 cycles apart, done after 20
        for (int i = 0; i < 10; i++) begin
            pulse_tick();
            chk("conv_fs", 32'(fs_vec), 32'b0001);
            fd_after(3, 20);
            chk("conv_cnt_step", 32'(bus.conv_cnt), 32'(i + 1));
            step(79);
        end
        chk("conv10_cnt",     32'(bus.conv_cnt), 32'd10);
        chk("conv10_overrun", 32'(bus.overrun),  32'd0);
        chk("conv10_state",   32'(bus.state),    32'd4);

        // Two ticks during one conversion
        pulse_tick();
        step(2);
        pulse_tick();
        step(2);
        pulse_tick();
        chk("ovr_set", 32'(bus.overrun), 32'd1);
        fd_after(3, 14);
        chk("ovr_wait", 32'(bus.state),    32'd4);
        chk("ovr_cnt",  32'(bus.conv_cnt), 32'd11);
        step(1);
        chk("ovr_extra_conv", 32'(bus.state), 32'd5);
        fd_after(3, 3);
        chk("ovr_cnt2", 32'(bus.conv_cnt), 32'd12);
        pulse_clr();
        chk("ovr_clr",       32'(bus.overrun), 32'd0);
        chk("ovr_clr_state", 32'(bus.state),   32'd4);

        // cfg_upd during CONV -> CONF after WAIT
        pulse_tick();
        step(2);
        pulse_cfg();
        fd_after(3, 5);
        chk("cfgp_wait", 32'(bus.state),    32'd4);
        chk("cfgp_cnt",  32'(bus.conv_cnt), 32'd13);
        step(1);
        chk("cfgp_conf", 32'(bus.state), 32'd3);
        fd_after(2, 3);
        chk("cfgp_back", 32'(bus.state), 32'd4);

        // cfg_upd and conv_tick together in WAIT: CONF first, tick kept
        bus.cfg_upd   = 1'b1;
        bus.conv_tick = 1'b1;
        step(1);
        bus.cfg_upd   = 1'b0;
        bus.conv_tick = 1'b0;
        chk("both_conf", 32'(bus.state), 32'd3);
        fd_after(2, 3);
        chk("both_wait", 32'(bus.state), 32'd4);
        step(1);
        chk("both_conv", 32'(bus.state), 32'd5);
        fd_after(3, 3);
        chk("both_cnt", 32'(bus.conv_cnt), 32'd14);

        // run dropped during CONV -> IDLE after done
        pulse_tick();
        step(3);
        bus.run = 1'b0;
        fd_after(3, 5);
        chk("stop_state", 32'(bus.state),    32'd0);
        chk("stop_cnt",   32'(bus.conv_cnt), 32'd15);
        chk("stop_fs",    32'(fs_vec),       32'b0000);
        chk("stop_ready", 32'(bus.ready),    32'd0);
        step(2);
        chk("stop_hold", 32'(bus.state), 32'd0);

        // Stale fd_type held high while entering TYPE
        bus.run = 1'b1;
        step(1);
        chk("stale_init", 32'(bus.state), 32'd1);
        bus.fd_type = 1'b1;
        fd_after(0, 3);
        chk("stale_type", 32'(bus.state), 32'd2);
        step(5);
        chk("stale_hold",    32'(bus.state), 32'd2);
        chk("stale_hold_fs", 32'(fs_vec),    32'b0100);
        bus.fd_type = 1'b0;
        step(1);
        bus.fd_type = 1'b1;
        step(1);
        bus.fd_type = 1'b0;
        chk("stale_conf", 32'(bus.state), 32'd3);
        fd_after(2, 3);
        chk("stale_wait", 32'(bus.state), 32'd4);

        // Counter wrap: conversions 16 and 17
        pulse_tick();
        fd_after(3, 3);
        chk("wrap_zero", 32'(bus.conv_cnt), 32'd0);
        pulse_tick();
        fd_after(3, 3);
        chk("wrap_one", 32'(bus.conv_cnt), 32'd1);

        // CONF timeout
        pulse_cfg();
        chk("tmo_conf", 32'(bus.state), 32'd3);
        step(99);
        chk("tmo_not_yet",    32'(bus.state), 32'd3);
        chk("tmo_not_yet_fs", 32'(fs_vec),    32'b0010);
        step(1);
        chk("tmo_err_state", 32'(bus.state),     32'd6);
        chk("tmo_err",       32'(bus.err),       32'd1);
        chk("tmo_err_stage", 32'(bus.err_stage), 32'd2);
        chk("tmo_fs",        32'(fs_vec),        32'b0000);
        chk("tmo_ready",     32'(bus.ready),     32'd0);
        step(3);
        chk("err_run_ignored", 32'(bus.state), 32'd6);
        pulse_clr();
        chk("errclr_state", 32'(bus.state),     32'd0);
        chk("errclr_err",   32'(bus.err),       32'd0);
        chk("errclr_stage", 32'(bus.err_stage), 32'd2);
        step(1);
        chk("errclr_restart", 32'(bus.state), 32'd1);

        // Asynchronous reset mid-stage
        #2 rst = 1'b1;
        #1;
        chk("arst_state", 32'(bus.state), 32'd0);
        chk("arst_fs",    32'(fs_vec),    32'b0000);
        bus.run = 1'b0;
        step(2);
        rst = 1'b0;
        step(3);
        chk("arst_hold",  32'(bus.state),     32'd0);
        chk("arst_stage", 32'(bus.err_stage), 32'd0);
        chk("arst_cnt",   32'(bus.conv_cnt),  32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/adc_seq_ctrl.md
ADC_SEQ_CTRL -- requirements
Module: adc_seq_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 16'd50000, max cycles a stage may wait for its done flag.
REQ-002 Parameter CNT_W, default 16, width of conversion counter.
REQ-003 clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 run  input  1  level; 1 = bring up array and convert, 0 = stop after current conversion.
REQ-006 conv_tick  input  1  one-cycle sample-rate strobe requesting one conversion.
REQ-007 cfg_upd  input  1  one-cycle strobe requesting re-configuration (new freq/filter).
REQ-008 err_clr  input  1  one-cycle strobe leaving error state.
REQ-009 fd_init, fd_type, fd_conf, fd_conv  input  1 each  AND-reduced done flags of the four-chip ADC array.
REQ-010 fs_init, fs_type, fs_conf, fs_conv  output  1 each  stage start levels to the ADC array.
REQ-011 ready  output  1  high in WAIT (array configured, idle).
REQ-012 err  output  1  high in ERR.
REQ-013 err_stage  output  2  stage that timed out: 0 init, 1 type, 2 conf, 3 conv.
REQ-014 overrun  output  1  sticky flag: conv_tick lost.
REQ-015 conv_cnt  output  CNT_W  completed conversions, wraps modulo 2^CNT_W.
REQ-016 state  output  3  encoded state: IDLE=0, INIT=1, TYPE=2, CONF=3, WAIT=4, CONV=5, ERR=6.

Function
REQ-017 All outputs registered; fs_x high exactly while state equals stage x, no glitch.
REQ-018 IDLE: run=1 sampled -> INIT next cycle; else stay.
REQ-019 Handshake: in stage x, fs_x held high until fd_x sampled 1; that edge moves state, fs_x low next cycle.
REQ-020 Sequence INIT -> TYPE -> CONF -> WAIT; each transition takes one cycle after fd_x sampled 1.
REQ-021 Stage entry requires fd_x low first: if fd_x already 1 on entry cycle it is ignored until seen 0 once (stale done rejected).
REQ-022 WAIT: priority run=0 -> IDLE; else pending cfg -> CONF; else conv_tick or pending tick -> CONV.
REQ-023 CONV: fd_conv sampled 1 (after REQ-021 release) -> WAIT, conv_cnt increments by 1 same edge.
REQ-024 cfg_upd arriving outside WAIT/CONF sets cfg_pend; cleared on CONF entry; repeat strobes merge.
REQ-025 conv_tick arriving in CONV or CONF sets tick_pend; second tick while tick_pend set sets overrun; tick_pend cleared on CONV entry.
REQ-026 conv_tick in INIT/TYPE/IDLE/ERR ignored, no overrun.
REQ-027 cfg_upd and conv_tick same cycle in WAIT: CONF first, tick kept pending.
REQ-028 run deasserted mid-stage: current stage completes, then IDLE instead of next stage; pending flags cleared in IDLE.
REQ-029 Timeout counter clears on every state entry, increments per cycle in INIT/TYPE/CONF/CONV; reaching TIMEOUT-1 without done -> ERR, err_stage latched.
REQ-030 ERR: all fs_x low, err=1; err_clr -> IDLE (err_stage retained until next ERR); run ignored.
REQ-031 overrun cleared only by rst or err_clr.
REQ-032 conv_cnt wraps from 2^CNT_W-1 to 0 silently.

Reset
REQ-033 rst asserted: state IDLE, all fs_x 0, ready 0, err 0, err_stage 0, overrun 0, conv_cnt 0, pending flags 0, timeout counter 0, asynchronously.
REQ-034 rst mid-stage aborts handshake immediately; after release, INIT restarts only with run=1.

Verification
REQ-035 Bring-up: run=1, fd_x pulse 3 cycles after each fs_x rise -> fs_init, fs_type, fs_conf high in order, ready=1, state=4.
REQ-036 Conversion: in WAIT, 10 conv_tick spaced 100 cycles, fd_conv after 20 -> conv_cnt=10, overrun=0.
REQ-037 Overrun: two conv_tick during one CONV -> one extra CONV after, overrun=1; err_clr -> overrun=0.
REQ-038 Timeout: TIMEOUT=100, fd_conf never set -> ERR 100 cycles after CONF entry, err_stage=2, fs_conf=0.
REQ-039 Reconfig/stop: cfg_upd during CONV -> CONF after WAIT; run=0 during CONV -> IDLE after fd_conv.
REQ-040 Stale done and wrap: fd_type held 1 entering TYPE ignored until dropped; CNT_W=4, 17 conversions -> conv_cnt=1.
